// File: rtl/ff_stim_checker.sv
// rtl/ff_stim_checker.sv - stimulus generator and self-scoring checker for the enabled, resettable ff
// Drives d/clk_en/rst_n from an LFSR, tracks the expected q, and counts mismatches on q and q_.
module ff_stim_checker #(
  parameter int         NUM_VECTORS = 64,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_d,
  output logic             dut_clk_en,
  output logic             dut_rst_n,
  input  logic             dut_q,
  input  logic             dut_q_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int         CW       = $clog2(NUM_VECTORS + 2);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [7:0]       lfsr;
  logic             lfsr_fb;
  logic             exp_q;
  logic [CNT_W-1:0] idx;
  logic             enter_reset;
  logic             compare;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    compare     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RESET;
      S_RESET: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        compare = 1'b1;
        if (cnt == CW'(NUM_VECTORS - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        compare   = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  if (start) state_nxt = S_RESET;
      default: state_nxt = S_IDLE;
    endcase
    enter_reset = (state_nxt == S_RESET) && (state != S_RESET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (state_nxt != state)  cnt <= '0;
    else if (busy)                cnt <= cnt + CW'(1);
  end

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Stimulus is loaded on the edge entering each RUN cycle, so RUN cycle k shows LFSR state k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= SEED_EFF;
      dut_d      <= 1'b0;
      dut_clk_en <= 1'b0;
      dut_rst_n  <= 1'b0;
    end else begin
      dut_rst_n <= (state_nxt != S_RESET);
      if (enter_reset) begin
        lfsr       <= SEED_EFF;
        dut_clk_en <= 1'b0;
      end else if (state_nxt == S_RUN) begin
        dut_d      <= lfsr[0];
        dut_clk_en <= lfsr[1] | lfsr[2];
        lfsr       <= {lfsr[6:0], lfsr_fb};
      end else begin
        dut_clk_en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          exp_q <= 1'b0;
    else if (!dut_rst_n) exp_q <= 1'b0;
    else if (dut_clk_en) exp_q <= dut_d;
  end

  assign mismatch = (dut_q != exp_q) || (dut_q_n == dut_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count     <= '0;
      first_err_idx <= '1;
      idx           <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (enter_reset) begin
      err_count     <= '0;
      first_err_idx <= '1;
      idx           <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      if (compare) begin
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (err_count == '0) first_err_idx <= idx;
        end
        if (idx != '1) idx <= idx + CNT_W'(1);
      end
      // The DRAIN comparison lands on the same edge, so fold it into pass directly.
      if (state == S_DRAIN) begin
        done <= 1'b1;
        pass <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_ff_stim_checker.sv
// tb/tb_ff_stim_checker.sv - directed bench for ff_stim_checker with a behavioural ff and fault modes
module tb_ff_stim_checker;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        dut_d, dut_clk_en, dut_rst_n, dut_q, dut_q_n;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx;

  logic        rst2_n, start2;
  logic        d2, en2, drst2, busy2, done2, pass2;
  logic [1:0]  err2, first2;

  int          mode;
  logic        ff_q;
  int          vectors = 0;
  int          miscompares = 0;

  bit          md [NV];
  bit          men[NV];
  bit          mexp[NV+1];
  bit          mign[NV+1];
  bit          rec_d [NV];
  bit          rec_en[NV];

  always #5 clk = ~clk;

  ff_stim_checker #(.NUM_VECTORS(NV), .SEED(8'hA5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_d(dut_d), .dut_clk_en(dut_clk_en), .dut_rst_n(dut_rst_n),
    .dut_q(dut_q), .dut_q_n(dut_q_n),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  ff_stim_checker #(.NUM_VECTORS(NV), .SEED(8'hA5), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .dut_d(d2), .dut_clk_en(en2), .dut_rst_n(drst2),
    .dut_q(1'b1), .dut_q_n(1'b0),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_idx(first2)
  );

  // Behavioural ff with injectable faults: 1 q stuck 0, 2 q_ equals q, 3 ignores clk_en.
  always_ff @(posedge clk or negedge dut_rst_n) begin
    if (!dut_rst_n)                    ff_q <= 1'b0;
    else if (dut_clk_en || mode == 3)  ff_q <= dut_d;
  end

  always_comb begin
    dut_q   = (mode == 1) ? 1'b0 : ff_q;
    dut_q_n = (mode == 2) ? dut_q : ~dut_q;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_model();
    logic [7:0] lf;
    lf = 8'hA5;
    mexp[0] = 1'b0;
    mign[0] = 1'b0;
    for (int k = 0; k < NV; k++) begin
      md[k]      = lf[0];
      men[k]     = lf[1] | lf[2];
      lf         = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      mexp[k+1]  = men[k] ? md[k] : mexp[k];
      mign[k+1]  = md[k];
    end
  endtask

  task automatic expect_errs(input int m, output int nerr, output int first);
    bit q, qn;
    nerr  = 0;
    first = -1;
    for (int i = 0; i <= NV; i++) begin
      q  = (m == 1) ? 1'b0 : (m == 3) ? mign[i] : mexp[i];
      qn = (m == 2) ? q : ~q;
      if ((q != mexp[i]) || (qn == q)) begin
        if (first < 0) first = i;
        nerr++;
      end
    end
  endtask

  task automatic run1(input bit mid_start, input int m);
    int n, bad, nerr, first;
    mode = m;
    expect_errs(m, nerr, first);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n   = 0;
    bad = 0;
    while (busy && n < 100) begin
      if (n == 0) begin
        check("clr_err", err_count, 0);
        check("clr_first", first_err_idx, 32'hFFFF);
        check("clr_done", {done, pass}, 0);
      end
      if (dut_rst_n !== (n >= 2)) bad++;
      if (n >= 2 && n < 2 + NV) begin
        if (dut_clk_en !== men[n-2] || dut_d !== md[n-2]) bad++;
        rec_d[n-2]  = dut_d;
        rec_en[n-2] = dut_clk_en;
      end else begin
        if (dut_clk_en !== 1'b0) bad++;
        if (n == 2 + NV && dut_d !== md[NV-1]) bad++;
      end
      n++;
      start = mid_start && (n == 8);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", n, NV + 3);
    check("stim_seq", bad, 0);
    check("done", done, 1);
    check("pass", pass, (nerr == 0));
    check("err_count", err_count, nerr);
    check("first_idx", first_err_idx, (first < 0) ? 32'hFFFF : first);
  endtask

  initial begin
    int n, zeros, first;
    rst_n  = 1'b0;
    start  = 1'b0;
    rst2_n = 1'b0;
    start2 = 1'b0;
    mode   = 0;
    build_model();
    repeat (3) @(negedge clk);
    check("rst_flags", {busy, done, pass, dut_rst_n, dut_clk_en, dut_d}, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_idx, 32'hFFFF);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    check("dut_rst_release", dut_rst_n, 1);

    run1(1'b0, 0);
    check("hand_seq", {rec_d[0], rec_en[0], rec_d[1], rec_en[1], rec_d[2], rec_en[2]}, 6'b110111);
    run1(1'b1, 1);
    run1(1'b0, 0);
    run1(1'b0, 2);
    run1(1'b0, 3);

    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {busy, done, pass, dut_rst_n, dut_clk_en, dut_d}, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_first", first_err_idx, 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_release", dut_rst_n, 1);
    run1(1'b0, 0);

    zeros = 0;
    first = -1;
    for (int i = 0; i <= NV; i++) begin
      if (!mexp[i]) begin
        if (first < 0) first = i;
        zeros++;
      end
    end
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("sat_done", done2, 1);
    check("sat_err", err2, (zeros >= 3) ? 3 : zeros);
    check("sat_first", first2, first);
    check("sat_pass", pass2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ff_stim_checker.md
# ff_stim_checker

Synthesizable stimulus generator and response checker for the team's enabled, resettable D flip-flop (`ff`). It is the driving end of the flip-flop's interface: it produces the data, enable and reset the flip-flop consumes, keeps a cycle-accurate reference model, and compares the flip-flop's `q`/`q_` against it. The block sits beside the DUT in on-chip self-test builds and replaces hand-written `#delay` stimulus with a repeatable, self-scoring run.

## Interface
Parameters:
- `NUM_VECTORS`, default 64: number of RUN cycles (stimulus vectors); must be ≥1.
- `SEED`, default 8'hA5: LFSR seed; a value of 0 is replaced by 8'h01.
- `CNT_W`, default 16: width of the error counter and error index.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, shared with the DUT.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a run.
- `dut_d`  out  1  data to the DUT's `d3`.
- `dut_clk_en`  out  1  DUT clock enable.
- `dut_rst_n`  out  1  DUT asynchronous active-low reset.
- `dut_q`  in  1  DUT `q`.
- `dut_q_n`  in  1  DUT `q_`.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until the next accepted `start`.
- `pass`  out  1  `done` with zero errors.
- `err_count`  out  CNT_W  mismatching comparisons, saturating at all-ones.
- `first_err_idx`  out  CNT_W  index of the first failing comparison; all-ones if there is none.

## Operation
- FSM states: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE: `start`=1 → RESET. RESET lasts 2 cycles with `dut_rst_n`=0, then → RUN. RUN lasts NUM_VECTORS cycles, then → DRAIN. DRAIN lasts 1 cycle, then → DONE. DONE: `start`=1 → RESET.
- `start` is ignored in RESET, RUN and DRAIN.
- Entering RESET does the following:
  - reloads the LFSR with SEED;
  - clears `err_count`, `done` and `pass`;
  - sets `first_err_idx` to all-ones;
  - clears the comparison index.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left. It advances once per RUN cycle.
- Stimulus outputs are registered. In each RUN cycle `dut_d`=lfsr[0] and `dut_clk_en`=lfsr[1]|lfsr[2]. Outside RUN, `dut_clk_en`=0 and `dut_d` holds its last value.
- Reference model `exp_q`:
  - cleared while `dut_rst_n`=0;
  - otherwise `exp_q` ← `dut_d` at each clock edge where `dut_clk_en`=1;
  - otherwise holds.
- Comparison in every RUN and DRAIN cycle, giving NUM_VECTORS+1 comparisons with indices 0..NUM_VECTORS:
  - error if `dut_q`≠`exp_q` or `dut_q_n`≠~`dut_q`;
  - at most one error is counted per cycle;
  - on the first error, `first_err_idx` ← the current index.
  - Index 0 checks the post-reset value (`q`=0).
- On entering DONE: `done`=1 and `pass`=(err_count==0).
- `err_count` saturates; `first_err_idx` is never overwritten after the first error.

## Timing
- Reset values:
  - `dut_d`=0, `dut_clk_en`=0, `dut_rst_n`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=all-ones;
  - FSM=IDLE, LFSR=SEED, `exp_q`=0.
- `dut_rst_n` goes to 1 at the first clock edge after `rst_n` deasserts.
- Asserting `rst_n` mid-run forces every reset value immediately (asynchronously) and holds the DUT in reset.
- Run sequence:
  - `start` sampled high in IDLE/DONE → RESET from the next cycle.
  - `busy`=1 exactly during RESET, RUN and DRAIN, for NUM_VECTORS+3 cycles.
  - `done`/`pass` rise on the edge that ends DRAIN, in the same cycle that `busy` falls.
- Stimulus driven in RUN cycle k is captured by the DUT at the edge ending cycle k. It is checked in cycle k+1 against `exp_q`, which is updated at that same edge.
- The DRAIN cycle exists to check the last vector.

## Test plan
- Ideal behavioural ff, NUM_VECTORS=16, `start` pulse → `busy` high 19 cycles, then `done`=1, `pass`=1, `err_count`=0, `first_err_idx`=16'hFFFF.
- DUT `q` stuck at 0 → `err_count` equals the number of comparisons with `exp_q`=1 (from the bench model); `first_err_idx` is the first such index; `pass`=0.
- DUT `q_` tied equal to `q` → `err_count`=17, `first_err_idx`=0.
- DUT ignoring clk_en (captures every RUN cycle) → errors only where `dut_clk_en`=0 and `dut_d`≠held value; counts match the bench model exactly.
- Both of the following:
  - `start` pulsed during RUN → no effect;
  - `rst_n` low mid-RUN → all outputs show reset values in the same cycle, and a subsequent run reproduces the identical `dut_d`/`dut_clk_en` sequence.
- `start` in DONE after a failing run → counters cleared, identical stimulus replayed. With CNT_W=2 and a stuck DUT, `err_count` saturates at 3 and `first_err_idx` is unchanged.
